// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter and instruction fetch sequencer
//
// Holds the PC and fetches instructions over a req/ack memory handshake that
// may take any number of cycles. Each fetched word goes to decode over a
// valid/ready handshake. Branch, jump, jump-register and exception redirects
// are applied, and any fetch already in flight when a redirect arrives is
// discarded.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   imem_req/addr     fetch request, held with a stable address until imem_ack
//   imem_ack/rdata    memory response
//   instr_valid/instr/instr_pc, instr_ready   instruction handshake to decode
//   redirect_*        single-cycle redirect request with type, base PC, operand
//   misalign_err      one-cycle pulse after a JR whose target is misaligned
//   fetch_count       number of instructions accepted by decode (wraps)
`timescale 1ns/1ps
module pc_fetch_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0080),
  parameter int                CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_type,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [ADDR_W-1:0] redirect_operand,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FLUSH} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] flush_addr_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              misalign_q;
  logic [CNT_W-1:0]  count_q;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_low;
  logic [ADDR_W-1:0] jump_high_mask;
  logic              jr_misaligned;
  logic [ADDR_W-1:0] target_d;

  // Jump keeps the top bits of base+4 above bit 28; building it with a mask
  // keeps the expression legal down to ADDR_W == 28.
  assign seq_pc         = redirect_base + ADDR_W'(4);
  assign jump_low       = ADDR_W'({redirect_operand[25:0], 2'b00});
  assign jump_high_mask = {ADDR_W{1'b1}} << 28;
  assign jr_misaligned  = (redirect_type == 2'b10) && (redirect_operand[1:0] != 2'b00);

  always_comb begin
    target_d = EXC_VECTOR;
    unique case (redirect_type)
      2'b00: target_d = seq_pc + (redirect_operand << 2);
      2'b01: target_d = (seq_pc & jump_high_mask) | jump_low;
      2'b10: target_d = jr_misaligned ? EXC_VECTOR : redirect_operand;
      2'b11: target_d = EXC_VECTOR;
      default: target_d = EXC_VECTOR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      flush_addr_q <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      misalign_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      misalign_q <= redirect_valid && (state_q != BOOT) && jr_misaligned;
      case (state_q)
        BOOT: state_q <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            pc_q <= target_d;
            // An outstanding request must still be completed at its old
            // address; with ack already here the data is simply dropped.
            if (!imem_ack) begin
              flush_addr_q <= pc_q;
              state_q      <= FLUSH;
            end
          end else if (imem_ack) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          // The current handshake still completes even when redirected.
          if (instr_ready) count_q <= count_q + 1'b1;
          if (redirect_valid) begin
            pc_q    <= target_d;
            state_q <= FETCH;
          end else if (instr_ready) begin
            pc_q    <= pc_q + ADDR_W'(4);
            state_q <= FETCH;
          end
        end
        FLUSH: begin
          if (redirect_valid) pc_q <= target_d;
          else if (imem_ack) state_q <= FETCH;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_req     = (state_q == FETCH) || (state_q == FLUSH);
  assign imem_addr    = (state_q == FLUSH) ? flush_addr_q : pc_q;
  assign instr_valid  = (state_q == HOLD);
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [1:0]  redirect_type;
  logic [31:0] redirect_base;
  logic [31:0] redirect_operand;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_total;
  int n_pass;

  pc_fetch_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .redirect_valid   (redirect_valid),
    .redirect_type    (redirect_type),
    .redirect_base    (redirect_base),
    .redirect_operand (redirect_operand),
    .misalign_err     (misalign_err),
    .fetch_count      (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req,     0);
    check({tag, "_valid"}, instr_valid,  0);
    check({tag, "_instr"}, instr,        0);
    check({tag, "_ipc"},   instr_pc,     0);
    check({tag, "_mis"},   misalign_err, 0);
    check({tag, "_cnt"},   fetch_count,  0);
  endtask

  // Starts at a negedge in FETCH; ack arrives in the lat-th request cycle.
  // Ends at a negedge in HOLD.
  task automatic fetch_one(input string tag, input logic [31:0] a, input logic [31:0] d, input int lat);
    for (int i = 1; i < lat; i++) begin
      check({tag, "_wait_req"},  imem_req,  1);
      check({tag, "_wait_addr"}, imem_addr, a);
      @(negedge clk);
    end
    check({tag, "_req"},  imem_req,  1);
    check({tag, "_addr"}, imem_addr, a);
    imem_ack   = 1'b1;
    imem_rdata = d;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check({tag, "_valid"}, instr_valid, 1);
    check({tag, "_instr"}, instr,       d);
    check({tag, "_ipc"},   instr_pc,    a);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [1:0] t, input logic [31:0] b, input logic [31:0] op);
    redirect_valid   = 1'b1;
    redirect_type    = t;
    redirect_base    = b;
    redirect_operand = op;
    @(negedge clk);
    redirect_valid   = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_type = 2'b00;
    redirect_base = 32'h0;
    redirect_operand = 32'h0;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");

    // Release: still in BOOT this cycle, request one cycle later.
    reset = 1'b0;
    #1 check("boot_req", imem_req, 0);
    @(negedge clk);

    // Sequential fetch, 1-cycle ack, decode always ready.
    for (int k = 0; k < 4; k++) begin
      fetch_one("seq", 32'(4 * k), 32'h1000_0000 + 32'(k), 1);
      accept();
    end
    check("seq_cnt",  fetch_count, 4);
    check("seq_next", imem_addr,   32'h10);

    // Ack latency 3, decode stalls 5 cycles.
    fetch_one("lat3", 32'h10, 32'hCAFE_0010, 3);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr,       32'hCAFE_0010);
      check("stall_ipc",   instr_pc,    32'h10);
      check("stall_cnt",   fetch_count, 4);
      @(negedge clk);
    end
    accept();
    check("lat3_cnt",  fetch_count, 5);
    check("lat3_next", imem_addr,   32'h14);

    // Branch in HOLD without ready: 0x100 + 4 + (-2 << 2) = 0xFC.
    fetch_one("pre_br", 32'h14, 32'h0000_0014, 1);
    redirect(2'b00, 32'h100, 32'hFFFF_FFFE);
    check("br_valid", instr_valid, 0);
    check("br_addr",  imem_addr,   32'hFC);
    check("br_cnt",   fetch_count, 5);

    // Jump in FETCH coinciding with ack: data dropped, fetch 0x1000_0100.
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_00FC;
    redirect(2'b01, 32'h1000_0000, 32'h40);
    imem_ack   = 1'b0;
    check("jmp_valid", instr_valid, 0);
    check("jmp_req",   imem_req,    1);
    check("jmp_addr",  imem_addr,   32'h1000_0100);

    // Branch while request outstanding: FLUSH holds old address until ack.
    redirect(2'b00, 32'h200, 32'h4);
    check("fl_req",  imem_req,  1);
    check("fl_addr", imem_addr, 32'h1000_0100);
    @(negedge clk);
    check("fl_addr2",  imem_addr,   32'h1000_0100);
    check("fl_valid2", instr_valid, 0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    check("fl_valid3", instr_valid, 0);
    fetch_one("fl_tgt", 32'h214, 32'h5555_0214, 1);
    accept();
    check("fl_cnt", fetch_count, 6);

    // Misaligned JR: one-cycle error pulse, fetch exception vector.
    fetch_one("pre_jr", 32'h218, 32'h0000_0218, 1);
    redirect(2'b10, 32'h218, 32'h203);
    check("jr_mis",   misalign_err, 1);
    check("jr_addr",  imem_addr,    32'h80);
    check("jr_valid", instr_valid,  0);
    @(negedge clk);
    check("jr_mis_off", misalign_err, 0);

    // Exception in HOLD with ready: handshake counts, next fetch 0x80.
    fetch_one("exc_pre", 32'h80, 32'h0000_0080, 2);
    instr_ready = 1'b1;
    redirect(2'b11, 32'h80, 32'h0);
    instr_ready = 1'b0;
    check("exc_cnt",   fetch_count,  7);
    check("exc_addr",  imem_addr,    32'h80);
    check("exc_valid", instr_valid,  0);
    check("exc_mis",   misalign_err, 0);

    // Reset asserted in FLUSH takes effect without a clock edge.
    redirect(2'b11, 32'h80, 32'h0);
    check("pre_rst_req", imem_req, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_flush");
    @(negedge clk);
    // Redirect during BOOT must be ignored.
    reset = 1'b0;
    redirect(2'b11, 32'h0, 32'h0);
    check("boot_ign_addr", imem_addr,    32'h0);
    check("boot_ign_mis",  misalign_err, 0);
    fetch_one("rb0", 32'h0, 32'h7777_0000, 1);
    accept();
    check("rb_cnt", fetch_count, 1);

    // Reset asserted in HOLD.
    fetch_one("rb1", 32'h4, 32'h7777_0004, 2);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_req",  imem_req,  1);
    check("rst2_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
